// File: rtl/alu_issue_queue.sv
// alu_issue_queue
//   Four-entry command FIFO in front of a combinational ALU. A three-state
//   FSM (IDLE -> EXEC -> DONE) issues the head command on registered
//   operand lines. It then captures the ALU result one edge later and holds
//   that result until the consumer takes it.
//
// Ports
//   clk, rst                  clock, async active-high reset
//   in_valid/in_ready         command handshake (in_ready = count < 4)
//   in_op, in_a, in_b, in_fwd command fields
//   alu_a, alu_b, alu_contl   registered operands/opcode to the ALU
//   alu_out                   combinational ALU result
//   res_valid/res_ready       result handshake
//   res_data, res_op          captured result and the opcode that made it
//   res_illegal               res_op is not a defined opcode
//   count                     queue occupancy 0..4
//
// Build option
//   ALU_ISSUE_FWD_EN : when defined, entries carry a fwd bit. A popped entry
//                      with fwd=1 takes operand a from the last captured
//                      result instead of its stored a.
module alu_issue_queue (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_op,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic       in_fwd,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_contl,
  input  logic [7:0] alu_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [3:0] res_op,
  output logic       res_illegal,
  output logic [2:0] count
);

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
`ifdef ALU_ISSUE_FWD_EN
    logic       fwd;
`endif
  } entry_t;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state;
  entry_t     mem [DEPTH];
  entry_t     head;
  entry_t     wr_ent;
  logic [1:0] wr_ptr, rd_ptr;  // 2-bit pointers wrap modulo 4 for free
  logic       push, pop;

`ifdef ALU_ISSUE_FWD_EN
  logic [7:0] last_res;
`else
  logic       unused_fwd;
  assign unused_fwd = in_fwd;
`endif

  // in_ready looks only at registered count. A pop in this cycle does not
  // open the queue until the next cycle.
  assign in_ready = (count != 3'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  // The FIFO is popped when the ALU lines are reloaded. That happens from
  // IDLE, or from DONE in the same edge that the consumer takes the result.
  assign pop = (count != 3'd0) &&
               ((state == IDLE) || (state == DONE && res_valid && res_ready));

  always_comb begin
    wr_ent    = '0;
    wr_ent.op = in_op;
    wr_ent.a  = in_a;
    wr_ent.b  = in_b;
`ifdef ALU_ISSUE_FWD_EN
    wr_ent.fwd = in_fwd;
`endif
  end

  function automatic logic op_illegal(input logic [3:0] op);
    case (op)
      4'b0010, 4'b0011, 4'b0111,
      4'b1000, 4'b1001, 4'b1010, 4'b1011,
      4'b1100, 4'b1101, 4'b1110: op_illegal = 1'b0;
      default:                   op_illegal = 1'b1;
    endcase
  endfunction

  // Payload storage is not reset. Occupancy alone decides which entries
  // are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_contl   <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_op      <= '0;
      res_illegal <= 1'b0;
`ifdef ALU_ISSUE_FWD_EN
      last_res    <= '0;
`endif
    end else begin
      // The ALU lines change only on a pop, so they hold outside issue.
      if (pop) begin
`ifdef ALU_ISSUE_FWD_EN
        alu_a <= head.fwd ? last_res : head.a;
`else
        alu_a <= head.a;
`endif
        alu_b     <= head.b;
        alu_contl <= head.op;
      end
      case (state)
        IDLE: if (pop) state <= EXEC;
        EXEC: begin
          res_data    <= alu_out;
          res_op      <= alu_contl;
          res_illegal <= op_illegal(alu_contl);
          res_valid   <= 1'b1;
`ifdef ALU_ISSUE_FWD_EN
          last_res    <= alu_out;
`endif
          state       <= DONE;
        end
        DONE: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            state     <= pop ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_fwd, res_ready;
  logic [3:0] in_op, alu_contl, res_op;
  logic [7:0] in_a, in_b, alu_a, alu_b, alu_out, res_data;
  logic       res_valid, res_illegal;
  logic [2:0] count;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  alu_issue_queue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_fwd(in_fwd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_contl(alu_contl), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .res_illegal(res_illegal),
    .count(count)
  );

  // Behavioural ALU: opcode 0000 and other undefined codes give 0x00.
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd2:  return a + b;
      4'd3:  return a - b;
      4'd7:  return 8'(a * b);
      4'd8:  return a & b;
      4'd9:  return a | b;
      4'd10: return a ^ b;
      4'd11: return ~a;
      4'd12: return a << 1;
      4'd13: return a >> 1;
      4'd14: return a;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic ill_f(input logic [3:0] op);
    return !(op == 4'd2 || op == 4'd3 || op == 4'd7 || (op >= 4'd8 && op <= 4'd14));
  endfunction

  assign alu_out = alu_f(alu_contl, alu_a, alu_b);

  // ---------------- scoreboard ----------------
  typedef struct { logic [7:0] d; logic [3:0] op; logic ill; } exp_t;
  exp_t       sbq[$];
  logic [7:0] mlast = 8'h00;
  logic [7:0] tr_a;
  exp_t       tr_e, mo_e;
  logic       hold_v = 1'b0;
  logic [12:0] hold;

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Accepted commands: the handshake sampled mid-cycle completes on the next edge.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      tr_a = in_a;
`ifdef ALU_ISSUE_FWD_EN
      if (in_fwd) tr_a = mlast;
`endif
      tr_e.d   = alu_f(in_op, tr_a, in_b);
      tr_e.op  = in_op;
      tr_e.ill = ill_f(in_op);
      mlast    = tr_e.d;
      sbq.push_back(tr_e);
    end
  end

  // Result monitor: compare on every handshake and check that a stalled result holds stable.
  always @(negedge clk) begin
    if (rst) hold_v = 1'b0;
    else begin
      if (res_valid && hold_v) begin
        vecs++;
        if ({res_data, res_op, res_illegal} !== hold) begin
          errs++;
          $display("FAIL hold_stable: got 0x%0h expected 0x%0h at %0t", {res_data, res_op, res_illegal}, hold, $time);
        end
      end
      hold_v = res_valid && !res_ready;
      hold   = {res_data, res_op, res_illegal};
      if (res_valid && res_ready) begin
        vecs++;
        if (sbq.size() == 0) begin
          errs++;
          $display("FAIL unexpected_result: got data 0x%0h op %0h, expected none at %0t", res_data, res_op, $time);
        end else begin
          mo_e = sbq.pop_front();
          if (res_data !== mo_e.d || res_op !== mo_e.op || res_illegal !== mo_e.ill) begin
            errs++;
            $display("FAIL result: got d=%0h op=%0h ill=%0b expected d=%0h op=%0h ill=%0b at %0t",
                     res_data, res_op, res_illegal, mo_e.d, mo_e.op, mo_e.ill, $time);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic f);
    int t = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_fwd = f;
    forever begin
      @(negedge clk);
      if (in_ready || t > 50) break;
      t++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sbq.size() != 0 && t < 400) begin @(posedge clk); t++; end
    chk("drain_left", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  int any_rv;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_fwd = 1'b0; res_ready = 1'b1;
    #3;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_alu", {alu_a, alu_b, alu_contl}, 0);
    chk("rst_res", {res_data, res_op, res_illegal}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // ADD latency: result valid right after the second edge following the push.
    push_cmd(4'b0010, 8'h05, 8'h03, 1'b0);
    @(negedge clk);
    chk("lat_count1", count, 1);
    chk("lat_rv_e1", res_valid, 0);
    @(negedge clk);
    chk("lat_rv_e2", res_valid, 0);
    @(negedge clk);
    chk("lat_rv_e3", res_valid, 1);
    chk("lat_data", res_data, 8'h08);
    @(posedge clk); #1;
    wait_drain();

    // SUB then MUL, in order.
    push_cmd(4'b0011, 8'h10, 8'h01, 1'b0);
    push_cmd(4'b0111, 8'h0F, 8'h0F, 1'b0);
    wait_drain();

    // Undefined opcode.
    push_cmd(4'b0000, 8'hFF, 8'hFF, 1'b0);
    wait_drain();

    // Forward case: result depends on build option, the model follows it.
    push_cmd(4'b0010, 8'h02, 8'h03, 1'b0);
    push_cmd(4'b0010, 8'h40, 8'h01, 1'b1);
    wait_drain();

    // Fill: one command in flight plus four queued, then a refused extra one.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(4'(8 + i), 8'(16 * i + 3), 8'(i + 1), 1'b0);
    @(negedge clk);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 4'b0010; in_a = 8'h77; in_b = 8'h11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_refuse", {count, in_ready}, {3'd4, 1'b0});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; res_ready = 1'b1;
    wait_drain();
    chk("drained_count", count, 0);

    // Randomised traffic with random back-pressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_op     = 4'($urandom);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_fwd    = 1'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; res_ready = 1'b1;
    wait_drain();

    // Reset while a result is held in DONE with three more queued.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(4'b0010, 8'(i), 8'h20, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_state", {count, res_valid}, {3'd3, 1'b1});
    @(posedge clk); #3;
    rst = 1'b1;
    sbq.delete();
    mlast = 8'h00;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rv", res_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0; res_ready = 1'b1;
    any_rv = 0;
    repeat (10) begin @(negedge clk); if (res_valid) any_rv = 1; end
    chk("post_rst_no_result", any_rv, 0);
    chk("post_rst_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
